// File: rtl/alu_multdiv_seq.sv
// Registered execute unit: single-cycle add/sub/and/or/sll/sra plus iterative signed mul/div.
// Build option ALU_BOOTH4_EN: radix-4 Booth multiplier (WIDTH/2 cycles) instead of radix-2 shift-add.
//
// state   | meaning
// IDLE    | waiting for ctrl_start
// RUN_MUL | multiply iterations in progress (busy=1)
// RUN_DIV | restoring-divide iterations in progress (busy=1)
// DONE    | result and flags valid, data_resultRDY=1; may accept a new op
module alu_multdiv_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               data_exception
);
    localparam int W2 = 2 * WIDTH;
`ifdef ALU_BOOTH4_EN
    localparam int MUL_ITER = WIDTH / 2;
`else
    localparam int MUL_ITER = WIDTH;
`endif
    // The accept edge performs the first iteration, so the counter covers the rest.
    localparam logic [SHAMT_W-1:0] MUL_CNT0 = SHAMT_W'(MUL_ITER - 2);
    localparam logic [SHAMT_W-1:0] DIV_CNT0 = SHAMT_W'(WIDTH - 2);
    localparam logic [WIDTH-1:0]   MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010,
                           OP_OR  = 5'b00011, OP_SLL = 5'b00100, OP_SRA = 5'b00101,
                           OP_MUL = 5'b00110, OP_DIV = 5'b00111;

    typedef enum logic [1:0] {S_IDLE, S_RUN_MUL, S_RUN_DIV, S_DONE} state_t;
    state_t state, state_n;

    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [W2-1:0]      acc, mcand;
    logic [WIDTH:0]     mplier;
    logic [WIDTH-1:0]   rem, quo;

    logic accept;
    assign busy           = (state == S_RUN_MUL) || (state == S_RUN_DIV);
    assign data_resultRDY = (state == S_DONE);
    assign accept         = ctrl_start && !busy;

    // Operands come straight from the inputs on accept, from the captured copies afterwards.
    logic [WIDTH-1:0] src_a, src_b, abs_a, abs_b;
    logic             src_neg;
    assign src_a   = accept ? data_operandA : a_q;
    assign src_b   = accept ? data_operandB : b_q;
    assign abs_a   = src_a[WIDTH-1] ? -src_a : src_a;
    assign abs_b   = src_b[WIDTH-1] ? -src_b : src_b;
    assign src_neg = src_a[WIDTH-1] ^ src_b[WIDTH-1];

    logic [WIDTH-1:0]        add_res, sub_res, sll_res, sra_res;
    logic signed [WIDTH-1:0] a_sgn;
    logic                    add_ov, sub_ov, is_ne, is_lt, div_zero, min_neg1;
    assign a_sgn    = src_a;
    assign add_res  = src_a + src_b;
    assign sub_res  = src_a - src_b;
    assign sll_res  = src_a << ctrl_shiftamt;
    assign sra_res  = a_sgn >>> ctrl_shiftamt;
    assign add_ov   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_res[WIDTH-1] != src_a[WIDTH-1]);
    assign sub_ov   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_res[WIDTH-1] != src_a[WIDTH-1]);
    assign is_ne    = (sub_res != '0);
    assign is_lt    = sub_res[WIDTH-1] ^ sub_ov;
    assign div_zero = (src_b == '0);
    assign min_neg1 = (src_a == MIN_VAL) && (src_b == '1);

    logic [W2-1:0]    m_acc_s, m_mcand_s, m_acc_n, m_mcand_n, mul_prod;
    logic [WIDTH:0]   m_mplier_s, m_mplier_n;
    logic [WIDTH-1:0] d_rem_s, d_quo_s, d_rem_n, d_quo_n, div_quot;
    logic [WIDTH:0]   d_sh, d_trial;
    logic             mul_ov;

    always_comb begin
        m_acc_s    = acc;
        m_mcand_s  = mcand;
        m_mplier_s = mplier;
        d_rem_s    = rem;
        d_quo_s    = quo;
        if (accept) begin
            m_acc_s    = '0;
`ifdef ALU_BOOTH4_EN
            m_mcand_s  = {{WIDTH{src_a[WIDTH-1]}}, src_a};
            m_mplier_s = {src_b, 1'b0};
`else
            m_mcand_s  = {{WIDTH{1'b0}}, abs_a};
            m_mplier_s = {1'b0, abs_b};
`endif
            d_rem_s    = '0;
            d_quo_s    = abs_a;
        end
    end

`ifdef ALU_BOOTH4_EN
    logic [W2-1:0] booth_pp;
    always_comb begin
        booth_pp = '0;
        case (m_mplier_s[2:0])
            3'b001, 3'b010: booth_pp = m_mcand_s;
            3'b011:         booth_pp = m_mcand_s << 1;
            3'b100:         booth_pp = -(m_mcand_s << 1);
            3'b101, 3'b110: booth_pp = -m_mcand_s;
            default:        booth_pp = '0;
        endcase
    end
    assign m_acc_n    = m_acc_s + booth_pp;
    assign m_mcand_n  = m_mcand_s << 2;
    assign m_mplier_n = {{2{m_mplier_s[WIDTH]}}, m_mplier_s[WIDTH:2]};
    assign mul_prod   = m_acc_n;
`else
    assign m_acc_n    = m_acc_s + (m_mplier_s[0] ? m_mcand_s : '0);
    assign m_mcand_n  = m_mcand_s << 1;
    assign m_mplier_n = m_mplier_s >> 1;
    assign mul_prod   = src_neg ? -m_acc_n : m_acc_n;
`endif
    assign mul_ov = !((&mul_prod[W2-1:WIDTH-1]) || !(|mul_prod[W2-1:WIDTH-1]));

    // Partial remainder stays below |B| <= 2^(WIDTH-1), so the shifted value fits WIDTH bits
    // and bit WIDTH of the trial subtraction is the borrow.
    assign d_sh     = {d_rem_s, d_quo_s[WIDTH-1]};
    assign d_trial  = d_sh - {1'b0, abs_b};
    assign d_rem_n  = d_trial[WIDTH] ? d_sh[WIDTH-1:0] : d_trial[WIDTH-1:0];
    assign d_quo_n  = {d_quo_s[WIDTH-2:0], !d_trial[WIDTH]};
    assign div_quot = src_neg ? -d_quo_n : d_quo_n;

    logic             wr, ovf_n, exc_n;
    logic [WIDTH-1:0] res_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr      = 1'b0;
        res_n   = '0;
        ovf_n   = 1'b0;
        exc_n   = 1'b0;
        if (accept) begin
            wr      = 1'b1;
            state_n = S_DONE;
            case (ctrl_ALUopcode)
                OP_ADD: begin res_n = add_res; ovf_n = add_ov; end
                OP_SUB: begin res_n = sub_res; ovf_n = sub_ov; end
                OP_AND: res_n = src_a & src_b;
                OP_OR:  res_n = src_a | src_b;
                OP_SLL: res_n = sll_res;
                OP_SRA: res_n = sra_res;
                OP_MUL: begin
                    wr      = 1'b0;
                    state_n = S_RUN_MUL;
                    cnt_n   = MUL_CNT0;
                end
                OP_DIV: begin
                    if (div_zero) begin
                        exc_n = 1'b1;
                    end else begin
                        wr      = 1'b0;
                        state_n = S_RUN_DIV;
                        cnt_n   = DIV_CNT0;
                    end
                end
                default: exc_n = 1'b1;
            endcase
        end else begin
            case (state)
                S_RUN_MUL, S_RUN_DIV: begin
                    if (cnt == '0) begin
                        wr      = 1'b1;
                        state_n = S_DONE;
                        res_n   = (state == S_RUN_MUL) ? mul_prod[WIDTH-1:0] : div_quot;
                        ovf_n   = (state == S_RUN_MUL) ? mul_ov : min_neg1;
                    end else begin
                        cnt_n = cnt - SHAMT_W'(1);
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            rem            <= '0;
            quo            <= '0;
            data_result    <= '0;
            isNotEqual     <= 1'b0;
            isLessThan     <= 1'b0;
            overflow       <= 1'b0;
            data_exception <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (accept) begin
                a_q <= data_operandA;
                b_q <= data_operandB;
            end
            if (accept || busy) begin
                acc    <= m_acc_n;
                mcand  <= m_mcand_n;
                mplier <= m_mplier_n;
                rem    <= d_rem_n;
                quo    <= d_quo_n;
            end
            if (wr) begin
                data_result    <= res_n;
                overflow       <= ovf_n;
                data_exception <= exc_n;
                isNotEqual     <= is_ne;
                isLessThan     <= is_lt;
            end
        end
    end
endmodule

// File: tb/tb_alu_multdiv_seq.sv
// Directed bench for alu_multdiv_seq: vector table plus hand sequences for stalls, back-to-back ops and reset.
module tb_alu_multdiv_seq;
    localparam int WIDTH = 32;
`ifdef ALU_BOOTH4_EN
    localparam int MUL_LAT = 16;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                           OP_SLL = 5'd4, OP_SRA = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7,
                           OP_BAD = 5'd8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ctrl_start = 1'b0;
    logic [4:0]       ctrl_ALUopcode = '0;
    logic [4:0]       ctrl_shiftamt = '0;
    logic [WIDTH-1:0] data_operandA = '0;
    logic [WIDTH-1:0] data_operandB = '0;
    logic [WIDTH-1:0] data_result;
    logic             data_resultRDY, busy, isNotEqual, isLessThan, overflow, data_exception;

    always #5 clock = ~clock;

    alu_multdiv_seq #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .data_exception (data_exception)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf;
        logic        exc;
        logic        ne;
        logic        lt;
        int          lat;
    } vec_t;

    vec_t vt[20];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        ctrl_start     = 1'b1;
    endtask

    // Called at the negedge after the accept edge; latency 1 means RDY is already high there.
    task automatic wait_rdy(output int lat, output logic gap);
        lat = 1;
        gap = 1'b0;
        while (!data_resultRDY && lat < 200) begin
            if (!busy) gap = 1'b1;
            @(negedge clock);
            lat++;
        end
    endtask

    int   lat;
    logic gap;
    int   rdy_seen;

    initial begin
        vt[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vt[1]  = '{OP_SUB, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[2]  = '{OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vt[3]  = '{OP_OR,  32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[4]  = '{OP_SLL, 32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[5]  = '{OP_SRA, 32'h80000000, 32'h00000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        vt[6]  = '{OP_SUB, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        vt[7]  = '{OP_BAD, 32'h00000003, 32'h00000003, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vt[8]  = '{OP_MUL, 32'hFFFFFFFD, 32'h00000007, 5'd0,  32'hFFFFFFEB, 1'b0, 1'b0, 1'b1, 1'b1, MUL_LAT};
        vt[9]  = '{OP_MUL, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT};
        vt[10] = '{OP_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1, MUL_LAT};
        vt[11] = '{OP_MUL, 32'hFFFFFFFE, 32'hFFFFFFFD, 5'd0,  32'h00000006, 1'b0, 1'b0, 1'b1, 1'b0, MUL_LAT};
        vt[12] = '{OP_DIV, 32'hFFFFFFF9, 32'h00000002, 5'd0,  32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b1, DIV_LAT};
        vt[13] = '{OP_DIV, 32'h00000009, 32'h00000000, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vt[14] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1, DIV_LAT};
        vt[15] = '{OP_DIV, 32'd100,      32'd7,        5'd0,  32'd14,        1'b0, 1'b0, 1'b1, 1'b0, DIV_LAT};
        vt[16] = '{OP_DIV, 32'h00000007, 32'hFFFFFFFE, 5'd0,  32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b0, DIV_LAT};
        vt[17] = '{OP_DIV, 32'h80000000, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, DIV_LAT};
        vt[18] = '{OP_DIV, 32'h00000003, 32'h00000005, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, DIV_LAT};
        vt[19] = '{OP_SLL, 32'h000000FF, 32'h00000000, 5'd4,  32'h00000FF0, 1'b0, 1'b0, 1'b1, 1'b0, 1};

        // reset state
        repeat (2) @(negedge clock);
        check("rst_result", data_result, 32'h0);
        check("rst_flags", {26'b0, data_resultRDY, busy, isNotEqual, isLessThan, overflow, data_exception}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // table vectors
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
            @(negedge clock);
            ctrl_start = 1'b0;
            wait_rdy(lat, gap);
            check($sformatf("v%0d_result", i), data_result, vt[i].res);
            check($sformatf("v%0d_overflow", i), overflow, vt[i].ovf);
            check($sformatf("v%0d_exception", i), data_exception, vt[i].exc);
            check($sformatf("v%0d_isNotEqual", i), isNotEqual, vt[i].ne);
            check($sformatf("v%0d_isLessThan", i), isLessThan, vt[i].lt);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            if (vt[i].lat > 1) check($sformatf("v%0d_busy_gap", i), gap, 1'b0);
        end
        @(negedge clock);
        check("rdy_single_pulse", data_resultRDY, 1'b0);
        check("result_hold", data_result, 32'h00000FF0);

        // mul with ignored add starts at cycles 3 and 10, then add accepted in the RDY cycle
        drive(OP_MUL, 32'd6, 32'd7, 5'd0);
        @(negedge clock);
        ctrl_start = 1'b0;
        lat = 1;
        while (!data_resultRDY && lat < 200) begin
            if (lat == 3 || lat == 10) drive(OP_ADD, 32'd100, 32'd200, 5'd0);
            else ctrl_start = 1'b0;
            @(negedge clock);
            lat++;
        end
        ctrl_start = 1'b0;
        check("stall_mul_result", data_result, 32'd42);
        check("stall_mul_latency", lat, MUL_LAT);
        drive(OP_ADD, 32'd2, 32'd3, 5'd0);
        @(negedge clock);
        ctrl_start = 1'b0;
        check("rdy_cycle_add_rdy", data_resultRDY, 1'b1);
        check("rdy_cycle_add_result", data_result, 32'd5);
        @(negedge clock);
        check("no_queued_start", data_resultRDY, 1'b0);

        // eight back-to-back single-cycle ops
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
            @(negedge clock);
            check($sformatf("b2b%0d_rdy", i), data_resultRDY, 1'b1);
            check($sformatf("b2b%0d_result", i), data_result, vt[i].res);
        end
        ctrl_start = 1'b0;

        // reset in the middle of a divide
        drive(OP_ADD, 32'd5, 32'd6, 5'd0);
        @(negedge clock);
        check("pre_reset_add", data_result, 32'd11);
        drive(OP_DIV, 32'd1000, 32'd3, 5'd0);
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (9) @(negedge clock);
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_result", data_result, 32'h0);
        check("midrst_flags", {26'b0, data_resultRDY, busy, isNotEqual, isLessThan, overflow, data_exception}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("no_rdy_after_reset", rdy_seen, 0);
        drive(OP_DIV, 32'd100, 32'd7, 5'd0);
        @(negedge clock);
        ctrl_start = 1'b0;
        wait_rdy(lat, gap);
        check("post_reset_div", data_result, 32'd14);
        check("post_reset_div_latency", lat, DIV_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
